// File: rtl/ikaopll_op_sequencer_pkg.sv
// Shared constants and slot map for the operator sequencer.
// The slot map is also meant for the register file and the testbench.
package ikaopll_op_sequencer_pkg;

  localparam int NUM_SLOTS = 18;
  localparam int NUM_CH    = 9;
  localparam logic [4:0] SLOT_HH = 5'd13;
  localparam logic [4:0] SLOT_TT = 5'd14;

  typedef struct packed {
    logic [3:0] ch;
    logic       carrier;
  } slot_map_t;

  // Slots come in groups of six: three modulators, then the three matching carriers.
  function automatic slot_map_t slot_map(input logic [4:0] slot);
    slot_map_t  m;
    logic [4:0] g;
    logic [4:0] r;
    g = slot / 5'd6;
    r = slot - g * 5'd6;
    m.carrier = (r >= 5'd3);
    m.ch      = 4'(g * 5'd3 + (m.carrier ? r - 5'd3 : r));
    return m;
  endfunction

endpackage

// File: rtl/ikaopll_op_sequencer_dly.sv
// Enable-gated shift register with synchronous clear.
// The output is the last stage; a capture reaches it after DEPTH enables.
module ikaopll_op_sequencer_dly #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 3
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else if (en) begin
      stage[0] <= d;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[DEPTH-1];

endmodule

// File: rtl/ikaopll_op_sequencer.sv
// Operator slot sequencer: phi1 enable divider, 18-slot counter, frame strobes
// and the pipeline-aligned feedback-control flags for the shared operator datapath.
module ikaopll_op_sequencer
  import ikaopll_op_sequencer_pkg::*;
#(
  parameter int PIPE_DLY = 3
) (
  input  logic       i_EMUCLK,
  input  logic       i_IC,
  input  logic       i_phiM_PCEN_n,
  input  logic       i_RHYTHM,
  output logic       o_phi1_PCEN_n,
  output logic       o_phi1_NCEN_n,
  output logic [4:0] o_SLOT,
  output logic [3:0] o_CH,
  output logic       o_IS_CARRIER,
  output logic       o_CYCLE_00,
  output logic       o_CYCLE_17,
  output logic       o_SAMPLE_STB,
  output logic       o_INHIBIT_FDBK,
  output logic       o_HH_TT_SEL
);

  localparam logic [4:0] SLOT_LAST = 5'(NUM_SLOTS - 1);

  logic       div;
  logic [4:0] slot;
  logic       rhythm_latched;
  logic       phi1_ncen;
  logic       last_slot;
  logic       hhtt;
  slot_map_t  map;
  logic [1:0] dly_q;

  assign phi1_ncen = ~i_phiM_PCEN_n & div;
  assign last_slot = (slot == SLOT_LAST);

  always_ff @(posedge i_EMUCLK) begin
    if (i_IC) begin
      div            <= 1'b0;
      slot           <= 5'd0;
      rhythm_latched <= 1'b0;
    end else begin
      if (~i_phiM_PCEN_n) div <= ~div;
      if (phi1_ncen) begin
        slot <= last_slot ? 5'd0 : slot + 5'd1;
        // Rhythm mode only changes on frame boundaries.
        if (last_slot) rhythm_latched <= i_RHYTHM;
      end
    end
  end

  assign map  = slot_map(slot);
  assign hhtt = rhythm_latched & ((slot == SLOT_HH) | (slot == SLOT_TT));

  ikaopll_op_sequencer_dly #(
    .WIDTH(2),
    .DEPTH(PIPE_DLY)
  ) u_flag_dly (
    .clk(i_EMUCLK),
    .clr(i_IC),
    .en (phi1_ncen),
    .d  ({map.carrier, hhtt}),
    .q  (dly_q)
  );

  assign o_phi1_PCEN_n  = ~(~i_phiM_PCEN_n & ~div);
  assign o_phi1_NCEN_n  = ~phi1_ncen;
  assign o_SLOT         = slot;
  assign o_CH           = map.ch;
  assign o_IS_CARRIER   = map.carrier;
  assign o_CYCLE_00     = (slot == 5'd0);
  assign o_CYCLE_17     = last_slot;
  assign o_SAMPLE_STB   = last_slot & phi1_ncen;
  assign o_INHIBIT_FDBK = dly_q[1];
  assign o_HH_TT_SEL    = dly_q[0];

endmodule

// File: tb/tb_ikaopll_op_sequencer.sv
// Scoreboard bench for the operator sequencer: a phi1-cycle-count reference
// model queues expected outputs; a negedge monitor compares them.
module tb_ikaopll_op_sequencer;

  localparam int D = 3;

  logic       clk = 1'b0;
  logic       ic = 1'b1, pm_n = 1'b1, rhy = 1'b0;
  logic       pcen_n, ncen_n, car, c00, c17, stb, inh, hh;
  logic [4:0] slot;
  logic [3:0] ch;

  always #5 clk = ~clk;

  ikaopll_op_sequencer #(.PIPE_DLY(D)) dut (
    .i_EMUCLK(clk), .i_IC(ic), .i_phiM_PCEN_n(pm_n), .i_RHYTHM(rhy),
    .o_phi1_PCEN_n(pcen_n), .o_phi1_NCEN_n(ncen_n), .o_SLOT(slot), .o_CH(ch),
    .o_IS_CARRIER(car), .o_CYCLE_00(c00), .o_CYCLE_17(c17), .o_SAMPLE_STB(stb),
    .o_INHIBIT_FDBK(inh), .o_HH_TT_SEL(hh)
  );

  typedef struct {
    int slot, ch;
    bit car, c00, c17, stb, inh, hh, pcen_n, ncen_n;
  } exp_t;

  exp_t q[$];
  int checks = 0, errors = 0;

  // Model: k = phi1 cycles since reset, m = master enables since reset.
  int k = 0, m = 0;
  bit rhy_cur = 0;
  bit inh_hist[$], hh_hist[$];
  int ch_tab[18] = '{0,1,2,0,1,2,3,4,5,3,4,5,6,7,8,6,7,8};
  bit car_tab[18] = '{0,0,0,1,1,1,0,0,0,1,1,1,0,0,0,1,1,1};

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp_v);
    end
  endtask

  task automatic step(input bit a_ic, input bit a_pm, input bit a_rhy);
    exp_t e;
    int s;
    bit en, ph;
    @(posedge clk);
    #1;
    ic = a_ic; pm_n = a_pm; rhy = a_rhy;
    en = !a_pm;
    ph = (m % 2) == 1;
    s = k % 18;
    if (inh_hist.size() == k) begin
      inh_hist.push_back(car_tab[s]);
      hh_hist.push_back(rhy_cur && (s == 13 || s == 14));
    end
    e.slot   = s;
    e.ch     = ch_tab[s];
    e.car    = car_tab[s];
    e.c00    = (s == 0);
    e.c17    = (s == 17);
    e.pcen_n = !(en && !ph);
    e.ncen_n = !(en && ph);
    e.stb    = (s == 17) && en && ph;
    e.inh    = (k >= D) ? inh_hist[k-D] : 1'b0;
    e.hh     = (k >= D) ? hh_hist[k-D] : 1'b0;
    q.push_back(e);
    if (a_ic) begin
      k = 0; m = 0; rhy_cur = 0;
      inh_hist.delete(); hh_hist.delete();
    end else if (en) begin
      if (ph) begin
        if (s == 17) rhy_cur = a_rhy;
        k++;
      end
      m++;
    end
  endtask

  task automatic run_to_slot(input int target, input bit a_rhy);
    int n = 0;
    while ((k % 18) != target && n < 100) begin
      step(0, 0, a_rhy);
      n++;
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("slot",    int'(slot),   e.slot);
        chk("ch",      int'(ch),     e.ch);
        chk("carrier", int'(car),    int'(e.car));
        chk("cyc00",   int'(c00),    int'(e.c00));
        chk("cyc17",   int'(c17),    int'(e.c17));
        chk("stb",     int'(stb),    int'(e.stb));
        chk("inh_fb",  int'(inh),    int'(e.inh));
        chk("hh_tt",   int'(hh),     int'(e.hh));
        chk("pcen_n",  int'(pcen_n), int'(e.pcen_n));
        chk("ncen_n",  int'(ncen_n), int'(e.ncen_n));
        chk("both_low", int'(!pcen_n && !ncen_n), 0);
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    bit r = 0;
    repeat (3) step(1, 1, 0);
    // Four master enables from reset
    repeat (4) step(0, 0, 0);
    // Two full frames, rhythm off
    repeat (72) step(0, 0, 0);
    // Rhythm raised mid-frame; effective from the next frame only
    run_to_slot(5, 0);
    repeat (2 * 72) step(0, 0, 1);
    // Reset at slot 11 with carrier flags in flight
    run_to_slot(11, 1);
    step(1, 0, 1);
    repeat (40) step(0, 0, 0);
    // Freeze mid-frame
    run_to_slot(7, 0);
    step(0, 0, 0);
    repeat (50) step(0, 1, 0);
    repeat (40) step(0, 0, 0);
    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 49) == 0) r = ~r;
      step($urandom_range(0, 299) == 0, $urandom_range(0, 9) < 3, r);
    end
    step(0, 1, 0);
    @(negedge clk);
    @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ikaopll_op_sequencer.md
Name: ikaopll_op_sequencer

Overview:
- Timing generator and scheduler for the shared operator datapath (phase mod/logsin → attenuation/exp → fp-to-int with modulator feedback registers).
- Derives phi1 clock enables from the master clock enable and walks 18 time-multiplexed operator slots: 9 channels × modulator/carrier.
- Issues per-slot channel/operator select, frame strobes, and the pipeline-aligned feedback-control flags (INHIBIT_FDBK, HH_TT_SEL) the datapath consumes.

Parameters:
- PIPE_DLY, 3, phi1 cycles between a slot's issue and its feedback-control stage in the datapath (range 1..7).
- NUM_SLOTS, 18, operator slots per sample frame; fixed, not meant to be overridden.

Ports:
- i_EMUCLK  in  1  emulator master clock
- i_IC  in  1  synchronous active-high reset
- i_phiM_PCEN_n  in  1  master positive-edge clock enable, active low
- i_RHYTHM  in  1  rhythm mode enable from register file
- o_phi1_PCEN_n  out  1  phi1 positive-edge enable, active low
- o_phi1_NCEN_n  out  1  phi1 negative-edge enable, active low
- o_SLOT  out  5  current slot number, 0..17
- o_CH  out  4  channel of current slot, 0..8
- o_IS_CARRIER  out  1  current slot is a carrier
- o_CYCLE_00  out  1  high during slot 0
- o_CYCLE_17  out  1  high during slot 17
- o_SAMPLE_STB  out  1  one-EMUCLK pulse at end of frame
- o_INHIBIT_FDBK  out  1  delayed carrier flag for the datapath feedback path
- o_HH_TT_SEL  out  1  delayed HH/TT rhythm-slot flag

Behaviour:
- Divider: 1-bit register `div` toggles on every EMUCLK with i_phiM_PCEN_n==0.
  - o_phi1_PCEN_n = ~(~i_phiM_PCEN_n & ~div).
  - o_phi1_NCEN_n = ~(~i_phiM_PCEN_n & div).
  - Both are combinational from `div` and the input. They are never simultaneously low. Each is low once per two master enables.
- Slot counter:
  - Advances on EMUCLK when o_phi1_NCEN_n==0.
  - Counts 0..17, then wraps 17→0. No other states.
- Slot map, combinational from the counter:
  - Group g = slot/6, r = slot%6.
  - Carrier = (r>=3).
  - Channel = 3g + (r%3).
  - Order: M0 M1 M2 C0 C1 C2 M3 M4 M5 C3 C4 C5 M6 M7 M8 C6 C7 C8.
- Strobes:
  - o_CYCLE_00 = (slot==0); o_CYCLE_17 = (slot==17).
  - o_SAMPLE_STB = 1 exactly on the EMUCLK where slot==17 and o_phi1_NCEN_n==0, i.e. the wrap edge.
- Rhythm latch:
  - i_RHYTHM is sampled only at the wrap edge. It affects frames from the next slot 0 onward.
  - Changes mid-frame never alter the current frame.
- Raw flags per slot:
  - fdbk_inh = carrier.
  - hhtt = rhythm_latched & (slot==13 | slot==14), i.e. modulators of ch7 and ch8.
- Delay line:
  - PIPE_DLY-deep shift register of {fdbk_inh, hhtt}, shifted on each phi1 NCEN edge.
  - o_INHIBIT_FDBK and o_HH_TT_SEL are its last stage.
  - Latency is exactly PIPE_DLY phi1 cycles from the slot becoming current.
- Reset (i_IC==1 at an EMUCLK edge, regardless of enables):
  - div=0, slot=0, rhythm_latched=0, delay line all zero.
  - Outputs then: o_SLOT=0, o_CH=0, o_IS_CARRIER=0, o_CYCLE_00=1, o_CYCLE_17=0, o_SAMPLE_STB=0, o_INHIBIT_FDBK=0, o_HH_TT_SEL=0.
  - Enables follow the input: o_phi1_PCEN_n = i_phiM_PCEN_n, o_phi1_NCEN_n=1.
  - Reset mid-frame aborts immediately. While i_IC is held, counters do not advance even if enables pulse.
  - Reset takes priority over every simultaneous event.
- While i_phiM_PCEN_n is held high, all state freezes.

Decomposition:
- Shared package constants:
  - NUM_SLOTS=18, NUM_CH=9.
  - Slot indices SLOT_HH=13, SLOT_TT=14.
  - A function mapping slot→{channel, carrier} for reuse by the register file and bench.
- One sub-module: ikaopll_op_sequencer_dly, a parameterised enable-gated shift register with synchronous clear. It is used for the flag delay line.

Test Plan:
- Reset, then 4 master enables → div toggles; PCEN_n low on enables 1 and 3, NCEN_n low on 2 and 4; never both low.
- Run 36 phi1 cycles, rhythm off → o_SLOT 0..17 twice; o_CH/o_IS_CARRIER match map; slot 9 gives CH=3, carrier=1; SAMPLE_STB pulses exactly twice.
- PIPE_DLY=3 → o_INHIBIT_FDBK rises 3 phi1 cycles after slot 3 becomes current and falls 3 after slot 6; o_HH_TT_SEL stays 0.
- Assert i_RHYTHM at slot 5 → no HH_TT_SEL this frame; next frame o_HH_TT_SEL high for 2 phi1 cycles starting PIPE_DLY after slot 13.
- Assert i_IC at slot 11 with a feedback flag in flight → next edge: slot=0, all delayed flags 0; slot count resumes from 0 after release.
- Hold i_phiM_PCEN_n=1 for 50 EMUCLKs mid-frame → slot, flags, and divider unchanged; sequence resumes exactly where it stopped.
